bp_cfg_loader: RTL and testbench

- Post-reset configuration sequencer for a multicore BlackParrot instance.
- For each core it issues a fixed list of config-register writes over a single valid/ready config bus: freeze, core id, I$/D$ mode, CCE mode, boot PC.
- After every core is configured, it unfreezes every core and reports done.
- Sits between the top-level boot/host logic and the per-tile config-bus fan-out.

---
 rtl/bp_cfg_loader.sv | 151 +++++++++++++++
 tb/tb_bp_cfg_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: post-reset configuration sequencer for a multicore BlackParrot.
// For each core in turn it issues six config writes (FREEZE=1, CORE_ID, ICACHE_MODE,
// DCACHE_MODE, CCE_MODE, NPC) on one valid/ready bus. It then writes FREEZE=0 to every
// core in index order and reports done.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous, active-high reset
//   start_i      single-cycle start request; only acted on in IDLE or DONE
//   cfg_v_o      config write valid
//   cfg_core_o   target core index
//   cfg_addr_o   config register address
//   cfg_data_o   config write data (zero-extended fields)
//   cfg_ready_i  target accepts write; a transfer is cfg_v_o & cfg_ready_i
//   busy_o       high while writes are pending (CFG or UNFREEZE)
//   done_o       high in DONE until the next start_i
module bp_cfg_loader #(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned core_id_width_p  = 4,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter logic [63:0] boot_pc_p        = 64'h8000_0000,
  parameter int unsigned cce_mode_p       = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  output logic [core_id_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {StIdle, StCfg, StUnfreeze, StDone} state_e;

  localparam logic [core_id_width_p-1:0] LastCore = core_id_width_p'(num_core_p - 1);
  localparam logic [core_id_width_p-1:0] CoreOne  = core_id_width_p'(1);

  state_e                       r_state;
  logic [2:0]                   r_step;
  logic [core_id_width_p-1:0]   r_core;
  logic                         w_xfer;

  // Valid is decoded from state alone, so the handshake never loops through ready.
  assign w_xfer = cfg_v_o & cfg_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
      r_step  <= 3'd0;
      r_core  <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start_i) begin
            r_state <= StCfg;
            r_step  <= 3'd0;
            r_core  <= '0;
          end
        end
        StCfg: begin
          if (w_xfer) begin
            if (r_step == 3'd5) begin
              r_step <= 3'd0;
              if (r_core == LastCore) begin
                r_core  <= '0;
                r_state <= StUnfreeze;
              end else begin
                r_core <= r_core + CoreOne;
              end
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end
        StUnfreeze: begin
          if (w_xfer) begin
            if (r_core == LastCore) begin
              r_core  <= '0;
              r_state <= StDone;
            end else begin
              r_core <= r_core + CoreOne;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Bus fields are a pure decode of state/step/core, so they hold steady under backpressure
  // and read as zero whenever valid is low.
  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    unique case (r_state)
      StCfg: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = r_core;
        unique case (r_step)
          3'd0: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0001);
            cfg_data_o = cfg_data_width_p'(1);
          end
          3'd1: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0002);
            cfg_data_o = cfg_data_width_p'(r_core);
          end
          3'd2: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0003);
            cfg_data_o = cfg_data_width_p'(1);
          end
          3'd3: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0004);
            cfg_data_o = cfg_data_width_p'(1);
          end
          3'd4: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0005);
            cfg_data_o = cfg_data_width_p'(cce_mode_p);
          end
          3'd5: begin
            cfg_addr_o = cfg_addr_width_p'(16'h0006);
            cfg_data_o = cfg_data_width_p'(boot_pc_p);
          end
          default: begin
            cfg_addr_o = '0;
            cfg_data_o = '0;
          end
        endcase
      end
      StUnfreeze: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = r_core;
        cfg_addr_o = cfg_addr_width_p'(16'h0001);
        cfg_data_o = '0;
      end
      default: begin
        cfg_v_o = 1'b0;
      end
    endcase
  end

  assign busy_o = (r_state == StCfg) || (r_state == StUnfreeze);
  assign done_o = (r_state == StDone);

endmodule

// File: tb/tb_bp_cfg_loader.sv
module tb_bp_cfg_loader;

  localparam int          NC   = 4;
  localparam int          NX   = 7 * NC;
  localparam logic [63:0] BOOT = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single-core instance, cce_mode_p = 0
  logic        rst1, start1, rdy1, v1, busy1, done1;
  logic [3:0]  core1;
  logic [15:0] addr1;
  logic [63:0] data1;

  // Four-core instance, cce_mode_p = 1
  logic        rst4, start4, rdy4, v4, busy4, done4;
  logic [3:0]  core4;
  logic [15:0] addr4;
  logic [63:0] data4;

  bp_cfg_loader #(.num_core_p(1), .cce_mode_p(0)) u_dut1 (
    .clk_i(clk), .reset_i(rst1), .start_i(start1), .cfg_v_o(v1), .cfg_core_o(core1),
    .cfg_addr_o(addr1), .cfg_data_o(data1), .cfg_ready_i(rdy1), .busy_o(busy1), .done_o(done1)
  );

  bp_cfg_loader #(.num_core_p(NC), .cce_mode_p(1)) u_dut4 (
    .clk_i(clk), .reset_i(rst4), .start_i(start4), .cfg_v_o(v4), .cfg_core_o(core4),
    .cfg_addr_o(addr4), .cfg_data_o(data4), .cfg_ready_i(rdy4), .busy_o(busy4), .done_o(done4)
  );

  int checks = 0;
  int errors = 0;

  // Reference transfer list for the four-core instance
  logic [3:0]  m_core [NX];
  logic [15:0] m_addr [NX];
  logic [63:0] m_data [NX];

  // Expected single-core sequence
  logic [15:0] e1_addr [7] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd1};
  logic [63:0] e1_data [7] = '{64'd1, 64'd0, 64'd1, 64'd1, 64'd0, 64'h8000_0000, 64'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_model();
    int n = 0;
    for (int c = 0; c < NC; c++) begin
      logic [63:0] vals [6];
      vals = '{64'd1, 64'(c), 64'd1, 64'd1, 64'd1, BOOT};
      for (int r = 0; r < 6; r++) begin
        m_core[n] = 4'(c);
        m_addr[n] = 16'(r + 1);
        m_data[n] = vals[r];
        n++;
      end
    end
    for (int c = 0; c < NC; c++) begin
      m_core[n] = 4'(c);
      m_addr[n] = 16'd1;
      m_data[n] = 64'd0;
      n++;
    end
  endfunction

  // One full run on the four-core instance. pct: ready probability; spam: random start_i
  // during the run; stall_at: transfer index where ready is held low 50 cycles;
  // rst_at: transfer index where reset is applied instead of the transfer.
  task automatic run4(input int pct, input bit spam, input int stall_at, input int rst_at,
                      output int ncyc);
    int          idx;
    int          hold;
    bit          stall;
    logic [3:0]  pc;
    logic [15:0] pa;
    logic [63:0] pd;
    idx = 0; hold = 0; stall = 1'b0; pc = '0; pa = '0; pd = '0; ncyc = -1;
    @(negedge clk);
    start4 = 1'b1;
    rdy4   = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (stall) begin
        chk("stable_core", core4, pc);
        chk("stable_addr", addr4, pa);
        chk("stable_data", data4, pd);
      end
      chk("valid", v4, idx < NX);
      chk("busy", busy4, idx < NX);
      if (idx == NX) begin
        chk("done", done4, 1);
        ncyc = it;
        break;
      end
      chk("done_low", done4, 0);
      if (idx == rst_at) begin
        rst4   = 1'b1;
        rdy4   = 1'b1;
        start4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b0;
        chk("rst_valid", v4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_core", core4, 0);
        chk("rst_addr", addr4, 0);
        chk("rst_data", data4, 0);
        ncyc = it;
        return;
      end
      if (idx == stall_at && hold < 50) begin
        rdy4 = 1'b0;
        hold++;
        chk("stall_addr", addr4, 16'h6);
        chk("stall_data", data4, BOOT);
      end else begin
        rdy4 = ($urandom_range(99) < pct);
      end
      start4 = spam ? 1'($urandom_range(1)) : 1'b0;
      if (v4 && rdy4) begin
        chk("xfer_core", core4, m_core[idx]);
        chk("xfer_addr", addr4, m_addr[idx]);
        chk("xfer_data", data4, m_data[idx]);
        idx++;
      end
      stall = v4 && !rdy4;
      pc = core4; pa = addr4; pd = data4;
      @(negedge clk);
    end
    start4 = 1'b0;
    rdy4   = 1'b0;
    chk("xfer_count", idx, NX);
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", done4, 1);
      chk("idle_valid", v4, 0);
    end
  endtask

  initial begin
    int n;
    rst1 = 1'b1; start1 = 1'b0; rdy1 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; rdy4 = 1'b0;
    build_model();
    repeat (3) @(negedge clk);

    chk("reset_v1", v1, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_done1", done1, 0);
    chk("reset_addr1", addr1, 0);
    chk("reset_v4", v4, 0);
    chk("reset_busy4", busy4, 0);
    chk("reset_done4", done4, 0);
    chk("reset_data4", data4, 0);
    rst1 = 1'b0;
    rst4 = 1'b0;

    // Single core, ready tied high
    rdy1 = 1'b1;
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("c1_valid", v1, 1);
      chk("c1_core", core1, 0);
      chk("c1_addr", addr1, e1_addr[k]);
      chk("c1_data", data1, e1_data[k]);
      @(negedge clk);
    end
    chk("c1_done", done1, 1);
    chk("c1_valid_off", v1, 0);
    chk("c1_busy_off", busy1, 0);

    // Four cores, ready tied high: DONE latency 7*NC+1 after start
    run4(100, 1'b0, -1, -1, n);
    chk("done_latency", n, NX);

    // Re-run from DONE under 30% ready backpressure
    run4(30, 1'b0, -1, -1, n);

    // start_i toggled randomly during the sequence must not restart it
    run4(100, 1'b1, -1, -1, n);

    // Reset at the 3rd transfer of core 1
    run4(100, 1'b0, -1, 8, n);

    // Restart after reset from core 0 FREEZE, with a 50-cycle stall at step 5
    run4(100, 1'b0, 5, -1, n);
    chk("stall_latency", n, NX + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
